// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a registered read port.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_thr #(
   parameter  int DT_WIDTH   = 8,
   parameter  int F_DEPTH    = 16,
   parameter  int AFULL_TH   = F_DEPTH - 2,
   parameter  int AEMPTY_TH  = 2,
   localparam int FADD_WIDTH = $clog2(F_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wrt_en,
   input  logic [DT_WIDTH-1:0]   wrt_dt,
   input  logic                  rd_en,
   output logic [DT_WIDTH-1:0]   rd_dt,
   output logic                  rd_vld,
   output logic                  f_full,
   output logic                  f_empty,
   output logic                  f_afull,
   output logic                  f_aempty,
   output logic [FADD_WIDTH:0]   f_count,
   output logic                  f_ovf,
   output logic                  f_udf
);

   localparam logic [FADD_WIDTH:0] ONE_C    = (FADD_WIDTH+1)'(1);
   localparam logic [FADD_WIDTH:0] AFULL_C  = (FADD_WIDTH+1)'(AFULL_TH);
   localparam logic [FADD_WIDTH:0] AEMPTY_C = (FADD_WIDTH+1)'(AEMPTY_TH);

   logic [DT_WIDTH-1:0]   mem_q [0:F_DEPTH-1];

   logic [FADD_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [FADD_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [FADD_WIDTH:0]   count_q,  count_d;
   logic                  ovf_q,    ovf_d;
   logic                  udf_q,    udf_d;

   logic [FADD_WIDTH-1:0] wr_addr;
   logic [FADD_WIDTH-1:0] rd_addr;
   logic                  full;
   logic                  empty;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_addr = wr_ptr_q[FADD_WIDTH-1:0];
   assign rd_addr = rd_ptr_q[FADD_WIDTH-1:0];

   // Extra wrap bit distinguishes full from empty when the low bits match.
   assign full  = (wr_ptr_q[FADD_WIDTH] != rd_ptr_q[FADD_WIDTH]) &&
                  (wr_addr == rd_addr);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign wr_acc = wrt_en && !full;
   assign rd_acc = rd_en  && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (wrt_en & full);
      udf_d    = udf_q | (rd_en & empty);
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ONE_C;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is never cleared; reset only suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_addr] <= wrt_dt;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is shown as soon as it exists; rd_en pops it.
   assign rd_dt  = empty ? '0 : mem_q[rd_addr];
   assign rd_vld = !empty;
`else
   logic [DT_WIDTH-1:0] rd_dt_q,  rd_dt_d;
   logic                rd_vld_q, rd_vld_d;

   always_comb begin
      rd_dt_d  = rd_dt_q;
      rd_vld_d = rd_acc;
      if (rd_acc) begin
         rd_dt_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dt_q  <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         rd_dt_q  <= rd_dt_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   assign rd_dt  = rd_dt_q;
   assign rd_vld = rd_vld_q;
`endif

   assign f_full   = full;
   assign f_empty  = empty;
   assign f_count  = count_q;
   assign f_afull  = (count_q >= AFULL_C);
   assign f_aempty = (count_q <= AEMPTY_C);
   assign f_ovf    = ovf_q;
   assign f_udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed bench for sync_fifo_thr (DT_WIDTH=8, F_DEPTH=16, AFULL_TH=12, AEMPTY_TH=2).
module tb_sync_fifo_thr;

   logic       clk;
   logic       rst;
   logic       wrt_en;
   logic [7:0] wrt_dt;
   logic       rd_en;
   logic [7:0] rd_dt;
   logic       rd_vld;
   logic       f_full;
   logic       f_empty;
   logic       f_afull;
   logic       f_aempty;
   logic [4:0] f_count;
   logic       f_ovf;
   logic       f_udf;

   int checks = 0;
   int errors = 0;

   sync_fifo_thr #(
      .DT_WIDTH  (8),
      .F_DEPTH   (16),
      .AFULL_TH  (12),
      .AEMPTY_TH (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wrt_en   (wrt_en),
      .wrt_dt   (wrt_dt),
      .rd_en    (rd_en),
      .rd_dt    (rd_dt),
      .rd_vld   (rd_vld),
      .f_full   (f_full),
      .f_empty  (f_empty),
      .f_afull  (f_afull),
      .f_aempty (f_aempty),
      .f_count  (f_count),
      .f_ovf    (f_ovf),
      .f_udf    (f_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1);
   end

   // Drivers: inputs change 1 time unit after the rising edge.
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] d);
      wrt_en = 1'b1;
      wrt_dt = d;
      @(posedge clk);
      #1;
      wrt_en = 1'b0;
   endtask

   // Returns the word delivered by one pop, wherever the active mode shows it.
   task automatic do_pop(output logic vld, output logic [7:0] dt);
`ifdef SYNC_FIFO_FWFT_EN
      vld   = rd_vld;
      dt    = rd_dt;
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
`else
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      vld   = rd_vld;
      dt    = rd_dt;
`endif
   endtask

   task automatic do_both(input logic [7:0] d, output logic vld, output logic [7:0] dt);
      wrt_en = 1'b1;
      wrt_dt = d;
`ifdef SYNC_FIFO_FWFT_EN
      vld   = rd_vld;
      dt    = rd_dt;
      rd_en = 1'b1;
      @(posedge clk);
      #1;
`else
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      vld   = rd_vld;
      dt    = rd_dt;
`endif
      rd_en  = 1'b0;
      wrt_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(posedge clk);
      #1;
      checks++; if (f_empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b required 1", f_empty); end
      checks++; if (f_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b required 1", f_aempty); end
      checks++; if (f_count !== 5'd0)  begin errors++; $display("FAIL reset_count: got %0d required 0", f_count); end
      checks++; if (rd_vld !== 1'b0)   begin errors++; $display("FAIL reset_rd_vld: got %b required 0", rd_vld); end
      checks++; if (rd_dt !== 8'h00)   begin errors++; $display("FAIL reset_rd_dt: got %h required 00", rd_dt); end
      checks++; if (f_full !== 1'b0)   begin errors++; $display("FAIL reset_full: got %b required 0", f_full); end
      checks++; if (f_afull !== 1'b0)  begin errors++; $display("FAIL reset_afull: got %b required 0", f_afull); end
      checks++; if (f_ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b required 0", f_ovf); end
      checks++; if (f_udf !== 1'b0)    begin errors++; $display("FAIL reset_udf: got %b required 0", f_udf); end
   endtask

   task automatic test_fill_drain();
      logic       v;
      logic [7:0] d;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         do_write(8'(i));
         checks++; if (f_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d required %0d", i, f_count, i + 1); end
         checks++; if (f_afull !== ((i + 1) >= 12)) begin errors++; $display("FAIL fill_afull[%0d]: got %b required %b", i, f_afull, (i + 1) >= 12); end
         checks++; if (f_aempty !== ((i + 1) <= 2)) begin errors++; $display("FAIL fill_aempty[%0d]: got %b required %b", i, f_aempty, (i + 1) <= 2); end
         checks++; if (f_full !== ((i + 1) == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b required %b", i, f_full, (i + 1) == 16); end
      end
      checks++; if (f_ovf !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b required 0", f_ovf); end
      do_write(8'hAA);
      checks++; if (f_ovf !== 1'b1)    begin errors++; $display("FAIL ovf_set: got %b required 1", f_ovf); end
      checks++; if (f_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d required 16", f_count); end
      checks++; if (f_full !== 1'b1)   begin errors++; $display("FAIL ovf_full: got %b required 1", f_full); end
      for (int i = 0; i < 16; i++) begin
         do_pop(v, d);
         checks++; if (v !== 1'b1)   begin errors++; $display("FAIL drain_vld[%0d]: got %b required 1", i, v); end
         checks++; if (d !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h required %h", i, d, 8'(i)); end
         checks++; if (f_count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d required %0d", i, f_count, 15 - i); end
      end
      checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b required 1", f_empty); end
`ifndef SYNC_FIFO_FWFT_EN
      @(posedge clk);
      #1;
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b required 0", rd_vld); end
      checks++; if (rd_dt !== 8'h0F) begin errors++; $display("FAIL idle_hold: got %h required 0f", rd_dt); end
`endif
      checks++; if (f_udf !== 1'b0) begin errors++; $display("FAIL drain_no_udf: got %b required 0", f_udf); end
      do_pop(v, d);
      checks++; if (v !== 1'b0)      begin errors++; $display("FAIL udf_vld: got %b required 0", v); end
      checks++; if (f_udf !== 1'b1)  begin errors++; $display("FAIL udf_set: got %b required 1", f_udf); end
      checks++; if (f_count !== 5'd0) begin errors++; $display("FAIL udf_count: got %0d required 0", f_count); end
      checks++; if (f_ovf !== 1'b1)  begin errors++; $display("FAIL ovf_sticky: got %b required 1", f_ovf); end
   endtask

   task automatic test_wrap();
      logic       v;
      logic [7:0] d;
      do_reset();
      for (int blk = 0; blk < 2; blk++) begin
         for (int i = 0; i < 10; i++) do_write(8'(8'h10 + blk * 10 + i));
         checks++; if (f_count !== 5'd10) begin errors++; $display("FAIL wrap_count_hi[%0d]: got %0d required 10", blk, f_count); end
         for (int i = 0; i < 10; i++) begin
            do_pop(v, d);
            checks++; if (v !== 1'b1 || d !== 8'(8'h10 + blk * 10 + i)) begin
               errors++; $display("FAIL wrap_data[%0d]: got vld=%b %h required vld=1 %h", blk * 10 + i, v, d, 8'(8'h10 + blk * 10 + i));
            end
         end
         checks++; if (f_count !== 5'd0) begin errors++; $display("FAIL wrap_count_lo[%0d]: got %0d required 0", blk, f_count); end
      end
      checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b required 1", f_empty); end
      checks++; if (f_ovf !== 1'b0 || f_udf !== 1'b0) begin errors++; $display("FAIL wrap_flags: got ovf=%b udf=%b required ovf=0 udf=0", f_ovf, f_udf); end
   endtask

   task automatic test_simultaneous();
      logic       v;
      logic [7:0] d;
      do_reset();
      for (int i = 0; i < 5; i++) do_write(8'(8'h30 + i));
      for (int i = 0; i < 20; i++) begin
         do_both(8'(8'h35 + i), v, d);
         checks++; if (v !== 1'b1 || d !== 8'(8'h30 + i)) begin
            errors++; $display("FAIL simul_data[%0d]: got vld=%b %h required vld=1 %h", i, v, d, 8'(8'h30 + i));
         end
         checks++; if (f_count !== 5'd5) begin errors++; $display("FAIL simul_count[%0d]: got %0d required 5", i, f_count); end
      end
      // Simultaneous read and write while full: only the read lands.
      do_reset();
      for (int i = 0; i < 16; i++) do_write(8'(8'h40 + i));
      do_both(8'hEE, v, d);
      checks++; if (f_count !== 5'd15) begin errors++; $display("FAIL full_rw_count: got %0d required 15", f_count); end
      checks++; if (f_ovf !== 1'b1)    begin errors++; $display("FAIL full_rw_ovf: got %b required 1", f_ovf); end
      checks++; if (v !== 1'b1 || d !== 8'h40) begin errors++; $display("FAIL full_rw_data: got vld=%b %h required vld=1 40", v, d); end
      // Simultaneous read and write while empty: only the write lands.
      do_reset();
      do_both(8'h77, v, d);
      checks++; if (f_count !== 5'd1) begin errors++; $display("FAIL empty_rw_count: got %0d required 1", f_count); end
      checks++; if (f_udf !== 1'b1)   begin errors++; $display("FAIL empty_rw_udf: got %b required 1", f_udf); end
      checks++; if (v !== 1'b0)       begin errors++; $display("FAIL empty_rw_vld: got %b required 0", v); end
      do_pop(v, d);
      checks++; if (v !== 1'b1 || d !== 8'h77) begin errors++; $display("FAIL empty_rw_data: got vld=%b %h required vld=1 77", v, d); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 7; i++) do_write(8'(8'h60 + i));
      checks++; if (f_count !== 5'd7) begin errors++; $display("FAIL pre_rst_count: got %0d required 7", f_count); end
      rst    = 1'b1;
      wrt_en = 1'b1;
      wrt_dt = 8'h99;
      rd_en  = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      wrt_en = 1'b0;
      rd_en  = 1'b0;
      checks++; if (f_count !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d required 0", f_count); end
      checks++; if (f_empty !== 1'b1 || f_aempty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got empty=%b aempty=%b required 1 1", f_empty, f_aempty); end
      checks++; if (f_full !== 1'b0 || f_afull !== 1'b0) begin errors++; $display("FAIL midrst_full: got full=%b afull=%b required 0 0", f_full, f_afull); end
      checks++; if (f_ovf !== 1'b0 || f_udf !== 1'b0) begin errors++; $display("FAIL midrst_err: got ovf=%b udf=%b required 0 0", f_ovf, f_udf); end
      checks++; if (rd_vld !== 1'b0 || rd_dt !== 8'h00) begin errors++; $display("FAIL midrst_rd: got vld=%b %h required vld=0 00", rd_vld, rd_dt); end
   endtask

`ifdef SYNC_FIFO_FWFT_EN
   task automatic test_fwft();
      do_reset();
      do_write(8'h5A);
      checks++; if (rd_vld !== 1'b1 || rd_dt !== 8'h5A) begin errors++; $display("FAIL fwft_show: got vld=%b %h required vld=1 5a", rd_vld, rd_dt); end
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL fwft_pop: got %b required 0", rd_vld); end
      checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty: got %b required 1", f_empty); end
   endtask
`endif

   initial begin
      rst    = 1'b1;
      wrt_en = 1'b0;
      wrt_dt = 8'h00;
      rd_en  = 1'b0;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_mid_reset();
`ifdef SYNC_FIFO_FWFT_EN
      test_fwft();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
